// File: rtl/data_mem_ws_if.sv
// data_mem_ws_if: CPU-side request/response bus plus the contents-dump
// stream for the wait-state data memory. The requester (CPU or bench)
// uses the master modport and the memory uses the slave modport.
interface data_mem_ws_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    logic                  RD;
    logic                  WR;
    logic [DATA_W/8-1:0]   BE;
    logic [ADDR_W-1:0]     ADDRESS;
    logic [DATA_W-1:0]     DATAIN;
    logic [DATA_W-1:0]     DATAOUT;
    logic                  READY;
    logic                  ERR;
    logic                  DUMP;
    logic                  DUMP_VALID;
    logic [ADDR_W-3:0]     DUMP_ADDR;
    logic [DATA_W-1:0]     DUMP_DATA;
    logic                  DUMP_DONE;

    modport master (
        output RD, WR, BE, ADDRESS, DATAIN, DUMP,
        input  DATAOUT, READY, ERR, DUMP_VALID, DUMP_ADDR, DUMP_DATA, DUMP_DONE
    );

    modport slave (
        input  RD, WR, BE, ADDRESS, DATAIN, DUMP,
        output DATAOUT, READY, ERR, DUMP_VALID, DUMP_ADDR, DUMP_DATA, DUMP_DONE
    );
endinterface

// File: rtl/data_mem_ws.sv
// data_mem_ws: parametrised data memory with programmable read/write wait
// states, a one-cycle READY handshake, ERR reporting for misaligned or
// conflicting requests, and a streamed word-by-word contents dump.
// Optional feature macro: DMEM_BYTE_EN (defined -> writes honour BE,
// undefined -> every write is a full word and BE is ignored).
// The cycle in which READY is high (RESP) samples new requests exactly like
// IDLE, so back-to-back accesses need no extra idle cycle.
module data_mem_ws #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic         CLK,
    input  logic         RST_n,
    data_mem_ws_if.slave bus
);
    localparam int DEPTH  = 2 ** (ADDR_W - 2);
    localparam int NBYTES = DATA_W / 8;
    localparam int IDX_W  = ADDR_W - 2;

    localparam logic [3:0]       RD_LAT_C = 4'(RD_LAT);
    localparam logic [3:0]       WR_LAT_C = 4'(WR_LAT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        RESP,
        DUMP
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [IDX_W-1:0]  addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] dataOut_q;
    logic              ready_q;
    logic              err_q;
    logic              dumpValid_q;
    logic [IDX_W-1:0]  dumpAddr_q;
    logic [DATA_W-1:0] dumpData_q;
    logic              dumpDone_q;
    logic              dumpPend_q;
    logic              dumpPrev_q;

`ifdef DMEM_BYTE_EN
    logic [NBYTES-1:0] be_q;
    logic [NBYTES-1:0] memBe;
`else
    logic              unusedBe;
    assign unusedBe = ^bus.BE;
`endif

    logic              newDump;
    logic              startDump;
    logic              reqErr;
    logic              reqRd;
    logic              reqWr;
    logic [IDX_W-1:0]  reqIdx;
    logic [IDX_W-1:0]  dumpNext;

    logic              memWe;
    logic [IDX_W-1:0]  memIdx;
    logic [DATA_W-1:0] memData;

    // Decode the request seen this cycle; a dump counts only on a low-to-high
    // change of DUMP, so holding it high does not retrigger.
    always_comb begin
        newDump   = bus.DUMP && !dumpPrev_q;
        startDump = dumpPend_q || newDump;
        reqErr    = (bus.RD && bus.WR) ||
                    ((bus.RD || bus.WR) && (bus.ADDRESS[1:0] != 2'b00));
        reqRd     = bus.RD && !bus.WR && (bus.ADDRESS[1:0] == 2'b00);
        reqWr     = bus.WR && !bus.RD && (bus.ADDRESS[1:0] == 2'b00);
        reqIdx    = bus.ADDRESS[ADDR_W-1:2];
        dumpNext  = dumpAddr_q + IDX_W'(1);
    end

    // Select when and what to write: straight from the bus with no write
    // wait states, otherwise from the captured request at the end of WR_WAIT.
    always_comb begin
        memWe   = 1'b0;
        memIdx  = addr_q;
        memData = wdata_q;
`ifdef DMEM_BYTE_EN
        memBe   = be_q;
`endif
        if ((state_q == IDLE || state_q == RESP) && (WR_LAT == 0) &&
            !startDump && reqWr) begin
            memWe   = 1'b1;
            memIdx  = reqIdx;
            memData = bus.DATAIN;
`ifdef DMEM_BYTE_EN
            memBe   = bus.BE;
`endif
        end else if (state_q == WR_WAIT && cnt_q == WR_LAT_C) begin
            memWe = 1'b1;
        end
    end

    // Storage array; it is never cleared, and a reset edge blocks the commit.
`ifdef DMEM_BYTE_EN
    always_ff @(posedge CLK) begin
        if (RST_n && memWe) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (memBe[b]) begin
                    mem[memIdx][b*8 +: 8] <= memData[b*8 +: 8];
                end
            end
        end
    end
`else
    always_ff @(posedge CLK) begin
        if (RST_n && memWe) begin
            mem[memIdx] <= memData;
        end
    end
`endif

    // Access/dump sequencer with registered handshake and dump outputs.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            dataOut_q   <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            dumpValid_q <= 1'b0;
            dumpAddr_q  <= '0;
            dumpData_q  <= '0;
            dumpDone_q  <= 1'b0;
            dumpPend_q  <= 1'b0;
            dumpPrev_q  <= 1'b0;
`ifdef DMEM_BYTE_EN
            be_q        <= '0;
`endif
        end else begin
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            dumpDone_q <= 1'b0;
            dumpPrev_q <= bus.DUMP;
            case (state_q)
                IDLE, RESP: begin
                    state_q <= IDLE;
                    if (startDump) begin
                        dumpPend_q  <= 1'b0;
                        dumpValid_q <= 1'b1;
                        dumpAddr_q  <= '0;
                        dumpData_q  <= mem[IDX_W'(0)];
                        state_q     <= DUMP;
                    end else if (reqErr) begin
                        err_q <= 1'b1;
                    end else if (reqRd) begin
                        addr_q <= reqIdx;
                        if (RD_LAT == 0) begin
                            ready_q   <= 1'b1;
                            dataOut_q <= mem[reqIdx];
                            state_q   <= RESP;
                        end else begin
                            cnt_q   <= 4'd1;
                            state_q <= RD_WAIT;
                        end
                    end else if (reqWr) begin
                        addr_q  <= reqIdx;
                        wdata_q <= bus.DATAIN;
`ifdef DMEM_BYTE_EN
                        be_q    <= bus.BE;
`endif
                        if (WR_LAT == 0) begin
                            ready_q <= 1'b1;
                            state_q <= RESP;
                        end else begin
                            cnt_q   <= 4'd1;
                            state_q <= WR_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (newDump) begin
                        dumpPend_q <= 1'b1;
                    end
                    if (cnt_q == RD_LAT_C) begin
                        cnt_q     <= 4'd0;
                        ready_q   <= 1'b1;
                        dataOut_q <= mem[addr_q];
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                WR_WAIT: begin
                    if (newDump) begin
                        dumpPend_q <= 1'b1;
                    end
                    if (cnt_q == WR_LAT_C) begin
                        cnt_q   <= 4'd0;
                        ready_q <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DUMP: begin
                    if (newDump) begin
                        dumpPend_q <= 1'b1;
                    end
                    if (dumpAddr_q == LAST_IDX) begin
                        dumpValid_q <= 1'b0;
                        dumpDone_q  <= 1'b1;
                        dumpAddr_q  <= '0;
                        state_q     <= IDLE;
                    end else begin
                        dumpAddr_q <= dumpNext;
                        dumpData_q <= mem[dumpNext];
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.DATAOUT    = dataOut_q;
    assign bus.READY      = ready_q;
    assign bus.ERR        = err_q;
    assign bus.DUMP_VALID = dumpValid_q;
    assign bus.DUMP_ADDR  = dumpAddr_q;
    assign bus.DUMP_DATA  = dumpData_q;
    assign bus.DUMP_DONE  = dumpDone_q;
endmodule

// File: tb/tb_data_mem_ws.sv
// tb_data_mem_ws: directed plus randomized bench for data_mem_ws with a
// 16-word memory (ADDR_W=6), RD_LAT=2, WR_LAT=1. The expected memory image
// is a plain word array updated by the byte-enable rule; expected timing is
// taken directly from the latency parameters.
module tb_data_mem_ws;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int RL = 2;
    localparam int WL = 1;
    localparam int NW = 16;

    logic CLK = 1'b0;
    logic RST_n = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    logic [DW-1:0] model [NW];
    logic [DW-1:0] lastRead;
    logic [DW-1:0] oldVal;
    logic [DW-1:0] expMerge;

    data_mem_ws_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    data_mem_ws #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .RD_LAT(RL),
        .WR_LAT(WL)
    ) dut (
        .CLK  (CLK),
        .RST_n(RST_n),
        .bus  (bus)
    );

    // Free-running 100 MHz clock.
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data,
                                 input logic [DW/8-1:0] be,
                                 input logic dump);
        bus.RD      = rd;
        bus.WR      = wr;
        bus.ADDRESS = addr;
        bus.DATAIN  = data;
        bus.BE      = be;
        bus.DUMP    = dump;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelWrite(input logic [AW-1:0] addr,
                              input logic [DW-1:0] data,
                              input logic [DW/8-1:0] be);
        int idx;
        idx = int'(addr >> 2);
`ifdef DMEM_BYTE_EN
        for (int b = 0; b < DW / 8; b++) begin
            if (be[b]) begin
                model[idx][b*8 +: 8] = data[b*8 +: 8];
            end
        end
`else
        if (be == be) begin
            model[idx] = data;
        end
`endif
    endtask

    // One aligned access; optional junk requests during the wait cycles
    // must be ignored by the memory.
    task automatic doAccess(input bit isWr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data,
                            input logic [DW/8-1:0] be, input bit noise);
        int lat;
        int idx;
        lat = isWr ? WL : RL;
        idx = int'(addr >> 2);
        applyStimulus(!isWr, isWr, addr, data, be, 1'b0);
        tick();
        applyIdle();
        for (int k = 0; k < lat; k++) begin
            checkOutput("ready-wait", 64'(bus.READY), 64'd0);
            if (noise) begin
                applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              AW'($urandom), $urandom, 4'($urandom), 1'b0);
            end
            tick();
        end
        applyIdle();
        checkOutput("ready", 64'(bus.READY), 64'd1);
        checkOutput("err-on-ready", 64'(bus.ERR), 64'd0);
        if (isWr) begin
            modelWrite(addr, data, be);
            checkOutput("dataout-hold", 64'(bus.DATAOUT), 64'(lastRead));
        end else begin
            checkOutput("dataout", 64'(bus.DATAOUT), 64'(model[idx]));
            lastRead = model[idx];
        end
    endtask

    task automatic doError(input logic rd, input logic wr,
                           input logic [AW-1:0] addr);
        applyStimulus(rd, wr, addr, $urandom, 4'hF, 1'b0);
        tick();
        applyIdle();
        checkOutput("err-pulse", 64'(bus.ERR), 64'd1);
        checkOutput("err-no-ready", 64'(bus.READY), 64'd0);
        tick();
        checkOutput("err-one-cycle", 64'(bus.ERR), 64'd0);
        checkOutput("err-no-ready-after", 64'(bus.READY), 64'd0);
    endtask

    task automatic checkDumpStream();
        for (int i = 0; i < NW; i++) begin
            checkOutput("dump-valid", 64'(bus.DUMP_VALID), 64'd1);
            checkOutput("dump-addr", 64'(bus.DUMP_ADDR), 64'(i));
            checkOutput("dump-data", 64'(bus.DUMP_DATA), 64'(model[i]));
            checkOutput("dump-done-early", 64'(bus.DUMP_DONE), 64'd0);
            tick();
        end
        checkOutput("dump-done", 64'(bus.DUMP_DONE), 64'd1);
        checkOutput("dump-valid-end", 64'(bus.DUMP_VALID), 64'd0);
        checkOutput("dump-addr-end", 64'(bus.DUMP_ADDR), 64'd0);
        tick();
        checkOutput("dump-done-pulse", 64'(bus.DUMP_DONE), 64'd0);
    endtask

    initial begin
        logic [AW-1:0] a;
        int            r;
        applyIdle();
        lastRead = '0;
        for (int i = 0; i < NW; i++) begin
            model[i] = '0;
        end

        // Reset state
        RST_n = 1'b0;
        tick();
        tick();
        checkOutput("rst-ready", 64'(bus.READY), 64'd0);
        checkOutput("rst-err", 64'(bus.ERR), 64'd0);
        checkOutput("rst-dataout", 64'(bus.DATAOUT), 64'd0);
        checkOutput("rst-dump-valid", 64'(bus.DUMP_VALID), 64'd0);
        checkOutput("rst-dump-addr", 64'(bus.DUMP_ADDR), 64'd0);
        checkOutput("rst-dump-data", 64'(bus.DUMP_DATA), 64'd0);
        checkOutput("rst-dump-done", 64'(bus.DUMP_DONE), 64'd0);
        RST_n = 1'b1;
        tick();

        // Fill every word so all later reads and dumps are defined
        for (int i = 0; i < NW; i++) begin
            doAccess(1'b1, AW'(i * 4), $urandom, 4'hF, 1'b0);
        end

        // Basic write then read back
        doAccess(1'b1, 6'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        doAccess(1'b0, 6'h10, '0, '0, 1'b0);
        checkOutput("deadbeef", 64'(bus.DATAOUT), 64'hDEADBEEF);

        // Partial write merge
        doAccess(1'b1, 6'h20, 32'h11223344, 4'hF, 1'b0);
        doAccess(1'b1, 6'h20, 32'hAABBCCDD, 4'b0101, 1'b0);
        doAccess(1'b0, 6'h20, '0, '0, 1'b0);
`ifdef DMEM_BYTE_EN
        expMerge = 32'h11BB33DD;
`else
        expMerge = 32'hAABBCCDD;
`endif
        checkOutput("be-merge", 64'(bus.DATAOUT), 64'(expMerge));

        // Rejected requests leave memory untouched
        doError(1'b1, 1'b0, 6'h13);
        doError(1'b1, 1'b1, 6'h20);
        doAccess(1'b0, 6'h20, '0, '0, 1'b0);

        // Dump after writing 1..4 into words 0..3
        for (int i = 0; i < 4; i++) begin
            doAccess(1'b1, AW'(i * 4), DW'(i + 1), 4'hF, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
        tick();
        applyIdle();
        checkDumpStream();

        // Dump raised while a read waits: READY first, dump the cycle after
        applyStimulus(1'b1, 1'b0, 6'h08, '0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
        for (int k = 0; k < RL; k++) begin
            checkOutput("rdump-wait-ready", 64'(bus.READY), 64'd0);
            checkOutput("rdump-wait-valid", 64'(bus.DUMP_VALID), 64'd0);
            tick();
            applyIdle();
        end
        checkOutput("rdump-ready", 64'(bus.READY), 64'd1);
        checkOutput("rdump-data", 64'(bus.DATAOUT), 64'(model[2]));
        checkOutput("rdump-no-valid", 64'(bus.DUMP_VALID), 64'd0);
        lastRead = model[2];
        tick();
        checkDumpStream();

        // Randomized back-to-back traffic with occasional rejects
        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 9));
            a = AW'($urandom_range(0, NW - 1) * 4);
            if (r == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    doError(1'b1, 1'b1, a);
                end else begin
                    doError(1'($urandom_range(0, 1)), 1'b1,
                            a | AW'($urandom_range(1, 3)));
                end
            end else if (r < 5) begin
                doAccess(1'b1, a, $urandom, 4'($urandom), 1'($urandom_range(0, 1)));
            end else begin
                doAccess(1'b0, a, '0, '0, 1'($urandom_range(0, 1)));
            end
        end

        // Final image via dump
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
        tick();
        applyIdle();
        checkDumpStream();

        // Reset during a write wait: no READY, no commit
        oldVal = model[12];
        applyStimulus(1'b0, 1'b1, 6'h30, 32'h5, 4'hF, 1'b0);
        tick();
        applyIdle();
        RST_n = 1'b0;
        tick();
        checkOutput("rstw-ready", 64'(bus.READY), 64'd0);
        checkOutput("rstw-dataout", 64'(bus.DATAOUT), 64'd0);
        RST_n = 1'b1;
        lastRead = '0;
        tick();
        checkOutput("rstw-ready-after", 64'(bus.READY), 64'd0);
        doAccess(1'b0, 6'h30, '0, '0, 1'b0);
        checkOutput("rstw-old-value", 64'(bus.DATAOUT), 64'(oldVal));

        // Reset during a dump: stream stops and DUMP_DONE never appears
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
        tick();
        applyIdle();
        tick();
        tick();
        checkOutput("rstd-valid-before", 64'(bus.DUMP_VALID), 64'd1);
        RST_n = 1'b0;
        tick();
        RST_n = 1'b1;
        for (int k = 0; k < NW + 2; k++) begin
            checkOutput("rstd-no-valid", 64'(bus.DUMP_VALID), 64'd0);
            checkOutput("rstd-no-done", 64'(bus.DUMP_DONE), 64'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
